// File: rtl/acia_pkg.sv
// Shared ACIA definitions: receiver state encoding, R_PMC parity-mode codes,
// default oversampling ratio and the expected-parity helper.
package acia_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } acia_state_t;

  localparam logic [1:0] PMC_ODD   = 2'b00;
  localparam logic [1:0] PMC_EVEN  = 2'b01;
  localparam logic [1:0] PMC_MARK  = 2'b10;
  localparam logic [1:0] PMC_SPACE = 2'b11;

  // Value the parity bit must carry for a given data byte and mode.
  function automatic logic parityExpected(input logic [7:0] data, input logic [1:0] pmc);
    logic result;
    case (pmc)
      PMC_ODD:  result = ~^data;
      PMC_EVEN: result = ^data;
      PMC_MARK: result = 1'b1;
      default:  result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/acia_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input, with a
// configurable reset value so an idle line never looks active out of reset.
module acia_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/acia_rx.sv
// 6551-style ACIA receiver: 16x oversampled 8N/8P framing with a one-byte
// holding register carrying parity, framing and overrun status.
module acia_rx
  import acia_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic       BCLK,
  input  logic       RESET,
  input  logic       RXD,
  input  logic       R_PME,
  input  logic [1:0] R_PMC,
  input  logic       RXACK,
  output logic [7:0] RXDATA,
  output logic       RXFULL,
  output logic       PE,
  output logic       FE,
  output logic       OE,
  output logic       RXBUSY
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

  logic w_rxdS;
  logic w_ackS;

  acia_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_syncRxd (
    .i_clk   (BCLK),
    .i_rst_n (RESET),
    .i_d     (RXD),
    .o_q     (w_rxdS)
  );

  acia_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_syncAck (
    .i_clk   (BCLK),
    .i_rst_n (RESET),
    .i_d     (RXACK),
    .o_q     (w_ackS)
  );

  acia_state_t       r_state,  w_stateNext;
  logic [TICK_W-1:0] r_tick,   w_tickNext;
  logic [2:0]        r_bitCnt, w_bitCntNext;
  logic [7:0]        r_shift,  w_shiftNext;
  logic              r_armed,  w_armedNext;
  logic              r_parErr, w_parErrNext;
  logic              w_complete;

  logic [7:0] r_data;
  logic       r_full;
  logic       r_pe;
  logic       r_fe;
  logic       r_oe;
  logic       r_ackPrev;
  logic       w_ackRise;

  always_ff @(posedge BCLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= ST_IDLE;
      r_tick   <= '0;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_armed  <= 1'b0;
      r_parErr <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_tick   <= w_tickNext;
      r_bitCnt <= w_bitCntNext;
      r_shift  <= w_shiftNext;
      r_armed  <= w_armedNext;
      r_parErr <= w_parErrNext;
    end
  end

  // The armed flag demands a high line before any start edge, so a held
  // break yields exactly one frame instead of retriggering.
  always_comb begin
    w_stateNext  = r_state;
    w_tickNext   = r_tick;
    w_bitCntNext = r_bitCnt;
    w_shiftNext  = r_shift;
    w_armedNext  = r_armed;
    w_parErrNext = r_parErr;
    w_complete   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tickNext   = '0;
        w_bitCntNext = '0;
        if (w_rxdS) begin
          w_armedNext = 1'b1;
        end else if (r_armed) begin
          w_stateNext  = ST_START;
          w_armedNext  = 1'b0;
          w_parErrNext = 1'b0;
        end
      end
      ST_START: begin
        if (r_tick == TICK_MID) begin
          w_tickNext  = '0;
          w_stateNext = w_rxdS ? ST_IDLE : ST_DATA;
        end else begin
          w_tickNext = r_tick + TICK_ONE;
        end
      end
      ST_DATA: begin
        if (r_tick == TICK_LAST) begin
          w_tickNext            = '0;
          w_shiftNext[r_bitCnt] = w_rxdS;
          if (r_bitCnt == 3'd7) begin
            w_bitCntNext = '0;
            w_stateNext  = R_PME ? ST_PARITY : ST_STOP;
          end else begin
            w_bitCntNext = r_bitCnt + 3'd1;
          end
        end else begin
          w_tickNext = r_tick + TICK_ONE;
        end
      end
      ST_PARITY: begin
        if (r_tick == TICK_LAST) begin
          w_tickNext   = '0;
          w_parErrNext = (w_rxdS != parityExpected(r_shift, R_PMC));
          w_stateNext  = ST_STOP;
        end else begin
          w_tickNext = r_tick + TICK_ONE;
        end
      end
      ST_STOP: begin
        if (r_tick == TICK_LAST) begin
          w_tickNext  = '0;
          w_complete  = 1'b1;
          w_stateNext = ST_IDLE;
        end else begin
          w_tickNext = r_tick + TICK_ONE;
        end
      end
      default: begin
        w_tickNext  = '0;
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  assign w_ackRise = w_ackS & ~r_ackPrev;

  // A completing frame takes priority over a simultaneous acknowledge.
  always_ff @(posedge BCLK or negedge RESET) begin
    if (!RESET) begin
      r_data    <= '0;
      r_full    <= 1'b0;
      r_pe      <= 1'b0;
      r_fe      <= 1'b0;
      r_oe      <= 1'b0;
      r_ackPrev <= 1'b0;
    end else begin
      r_ackPrev <= w_ackS;
      if (w_complete) begin
        if (!r_full || w_ackRise) begin
          r_data <= r_shift;
          r_pe   <= r_parErr;
          r_fe   <= ~w_rxdS;
          r_full <= 1'b1;
          r_oe   <= 1'b0;
        end else begin
          r_oe <= 1'b1;
        end
      end else if (w_ackRise) begin
        r_full <= 1'b0;
        r_pe   <= 1'b0;
        r_fe   <= 1'b0;
        r_oe   <= 1'b0;
      end
    end
  end

  assign RXDATA = r_data;
  assign RXFULL = r_full;
  assign PE     = r_pe;
  assign FE     = r_fe;
  assign OE     = r_oe;
  assign RXBUSY = (r_state != ST_IDLE);

endmodule
